// File: rtl/pkg_system_mdr.sv
// rtl/pkg_system_mdr.sv - shared types and constants for the MDR sequencer
package pkg_system_mdr;

   localparam int DW     = 16;
   localparam int DW2    = 2 * DW;
   localparam int N_MUL  = DW;
   localparam int N_DIV  = DW;
   localparam int N_SQRT = DW / 2;
   localparam int CNT_W  = $clog2(DW);

   typedef enum logic [1:0] {
      OP_MUL  = 2'd0,
      OP_DIV  = 2'd1,
      OP_SQRT = 2'd2,
      OP_ILL  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // An opcode that the datapath cannot execute
   function automatic logic op_is_illegal(op_t op);
      return (op == OP_ILL);
   endfunction

endpackage

// File: rtl/mdr_sequencer_iter_counter.sv
// rtl/mdr_sequencer_iter_counter.sv - iteration index counter that returns to 0 after its last step
module mdr_iter_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   assign last = (count == limit);

   // Count up while enabled; the final step drops back to 0 so the index never wraps past limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         if (last) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mdr_sequencer.sv
// rtl/mdr_sequencer.sv - control FSM for the iterative multiply/divide/square-root datapath
module mdr_sequencer
   import pkg_system_mdr::*;
#(
   parameter int DW = pkg_system_mdr::DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [1:0]             i_op,
   input  logic                   i_y_zero,
   input  logic                   i_clear,
   output logic                   o_ready,
   output logic                   o_load,
   output logic                   o_step_en,
   output logic [$clog2(DW)-1:0]  o_count,
   output logic                   o_last,
   output logic [1:0]             o_op,
   output logic                   o_done,
   output logic                   o_error
);

   localparam int CW = $clog2(DW);

   state_t        state;
   op_t           op_q;
   logic          ready_q;
   logic          load_q;
   logic          step_q;
   logic          done_q;
   logic          error_q;
   logic [CW-1:0] limit;
   logic [CW-1:0] cnt;
   logic          cnt_last;

   // Final iteration index for the latched opcode
   always_comb begin
      limit = CW'(DW - 1);
      case (op_q)
         OP_MUL:  limit = CW'(DW - 1);
         OP_DIV:  limit = CW'(DW - 1);
         OP_SQRT: limit = CW'(DW / 2 - 1);
         default: limit = CW'(DW - 1);
      endcase
   end

   mdr_iter_counter #(
      .CNT_W (CW)
   ) u_iter_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (i_clear),
      .en    (step_q),
      .limit (limit),
      .count (cnt),
      .last  (cnt_last)
   );

   // Sequencer state and registered handshake/control outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         op_q    <= OP_MUL;
         ready_q <= 1'b1;
         load_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else if (i_clear) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         load_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state   <= S_LOAD;
                  op_q    <= op_t'(i_op);
                  error_q <= 1'b0;
                  ready_q <= 1'b0;
                  load_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               load_q <= 1'b0;
               if (op_is_illegal(op_q) || (op_q == OP_DIV && i_y_zero)) begin
                  state   <= S_DONE;
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  state  <= S_ITER;
                  step_q <= 1'b1;
               end
            end
            S_ITER: begin
               if (cnt_last) begin
                  state  <= S_DONE;
                  step_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               load_q  <= 1'b0;
               step_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready   = ready_q;
   assign o_load    = load_q;
   assign o_step_en = step_q;
   assign o_count   = cnt;
   assign o_last    = step_q & cnt_last;
   assign o_op      = op_q;
   assign o_done    = done_q;
   assign o_error   = error_q;

endmodule
